collide_sched: RTL and testbench

COLLIDE_SCHED -- requirements
Module: collide_sched

---
 rtl/collide_sched.sv | 141 ++++++++++++++
 tb/tb_collide_sched.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collide_sched.sv
`default_nettype none
// ============================================================================
// collide_sched : word-serial overlap check of an obstacle map against one
//                 agent map slot; reports whether any cell is shared. Rev 1.0
// ============================================================================
module collide_sched #(
  parameter int WORD_W   = 256,
  parameter int WORD_NUM = 256,
  parameter int ADDR_W   = 8,
  parameter int SLOT_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [SLOT_W-1:0]        req_slot,
  output logic                     obs_rd_en,
  output logic [ADDR_W-1:0]        obs_addr,
  input  logic [WORD_W-1:0]        obs_rdata,
  output logic                     agt_rd_en,
  output logic [SLOT_W+ADDR_W-1:0] agt_addr,
  input  logic [WORD_W-1:0]        agt_rdata,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_collide,
  output logic [SLOT_W-1:0]        res_slot,
  output logic                     busy,
  output logic [15:0]              chk_cnt,
  output logic [15:0]              hit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORD_NUM - 1);
  localparam logic [15:0]       CNT_MAX   = 16'hFFFF;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              hit_q, hit_d;
  logic              dv_q;
  logic              rd_en;
  logic              hit_now;
  logic [15:0]       chk_cnt_q, chk_cnt_d;
  logic [15:0]       hit_cnt_q, hit_cnt_d;

  // Read data lands one cycle after the strobe; dv_q marks that cycle.
  assign hit_now = dv_q & (|(obs_rdata & agt_rdata));

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    slot_d    = slot_q;
    hit_d     = hit_q;
    chk_cnt_d = chk_cnt_q;
    hit_cnt_d = hit_cnt_q;
    rd_en     = 1'b0;
    req_ready = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          slot_d  = req_slot;
          word_d  = '0;
          hit_d   = 1'b0;
          state_d = READ;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (word_q != LAST_WORD) begin
          word_d = word_q + ADDR_W'(1);
        end else begin
          state_d = DRAIN;
        end
        // An early hit ends the scan; the read issued this cycle is discarded.
        if (hit_now) begin
          hit_d   = 1'b1;
          state_d = DONE;
        end
      end
      DRAIN: begin
        if (hit_now) begin
          hit_d = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
          if (chk_cnt_q != CNT_MAX) begin
            chk_cnt_d = chk_cnt_q + 16'd1;
          end
          if (hit_q && (hit_cnt_q != CNT_MAX)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      slot_q    <= '0;
      hit_q     <= 1'b0;
      dv_q      <= 1'b0;
      chk_cnt_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      slot_q    <= slot_d;
      hit_q     <= hit_d;
      dv_q      <= rd_en;
      chk_cnt_q <= chk_cnt_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign obs_rd_en   = rd_en;
  assign agt_rd_en   = rd_en;
  assign obs_addr    = word_q;
  assign agt_addr    = {slot_q, word_q};
  assign res_collide = hit_q;
  assign res_slot    = slot_q;
  assign busy        = (state_q != IDLE);
  assign chk_cnt     = chk_cnt_q;
  assign hit_cnt     = hit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_collide_sched.sv
`default_nettype none
// ============================================================================
// tb_collide_sched : directed checks of collide_sched against a latency-level
//                    model of the scan (4-word maps, 16-bit words). Rev 1.0
// ============================================================================
module tb_collide_sched;

  localparam int WORD_W   = 16;
  localparam int WORD_NUM = 4;
  localparam int ADDR_W   = 2;
  localparam int SLOT_W   = 4;

  logic                     clk;
  logic                     rst;
  logic                     req_valid;
  logic                     req_ready;
  logic [SLOT_W-1:0]        req_slot;
  logic                     obs_rd_en;
  logic [ADDR_W-1:0]        obs_addr;
  logic [WORD_W-1:0]        obs_rdata;
  logic                     agt_rd_en;
  logic [SLOT_W+ADDR_W-1:0] agt_addr;
  logic [WORD_W-1:0]        agt_rdata;
  logic                     res_valid;
  logic                     res_ready;
  logic                     res_collide;
  logic [SLOT_W-1:0]        res_slot;
  logic                     busy;
  logic [15:0]              chk_cnt;
  logic [15:0]              hit_cnt;

  collide_sched #(
    .WORD_W  (WORD_W),
    .WORD_NUM(WORD_NUM),
    .ADDR_W  (ADDR_W),
    .SLOT_W  (SLOT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_slot   (req_slot),
    .obs_rd_en  (obs_rd_en),
    .obs_addr   (obs_addr),
    .obs_rdata  (obs_rdata),
    .agt_rd_en  (agt_rd_en),
    .agt_addr   (agt_addr),
    .agt_rdata  (agt_rdata),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_collide(res_collide),
    .res_slot   (res_slot),
    .busy       (busy),
    .chk_cnt    (chk_cnt),
    .hit_cnt    (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Map contents and registered-read memories.
  logic [WORD_W-1:0] obs_mem [WORD_NUM];
  logic [WORD_W-1:0] agt_mem [16][WORD_NUM];

  initial begin
    obs_rdata = '0;
    agt_rdata = '0;
  end

  always @(posedge clk) begin
    if (obs_rd_en) obs_rdata <= obs_mem[obs_addr];
    if (agt_rd_en) agt_rdata <= agt_mem[agt_addr[SLOT_W+ADDR_W-1:ADDR_W]][agt_addr[ADDR_W-1:0]];
  end

  // Model: a check is fully described by the first overlapping word.
  function automatic int first_hit(input logic [SLOT_W-1:0] s);
    for (int k = 0; k < WORD_NUM; k++) begin
      if ((obs_mem[k] & agt_mem[s][k]) != '0) return k;
    end
    return -1;
  endfunction

  function automatic int lat_of(input int k);
    return (k < 0) ? WORD_NUM + 2 : k + 3;
  endfunction

  function automatic int reads_of(input int k);
    if (k < 0) return WORD_NUM;
    return (k + 2 > WORD_NUM) ? WORD_NUM : k + 2;
  endfunction

  bit          m_idle = 1'b1;
  int          m_t    = 0;
  int          m_lat  = 0;
  int          m_reads = 0;
  bit          m_col  = 1'b0;
  int          m_slot = 0;
  logic [15:0] m_chk  = '0;
  logic [15:0] m_hit  = '0;
  bit          preload = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle <= 1'b1;
      m_t    <= 0;
      m_chk  <= '0;
      m_hit  <= '0;
    end else if (m_idle) begin
      if (preload) begin
        m_chk <= 16'hFFFE;
        m_hit <= 16'hFFFE;
      end
      if (req_valid) begin
        m_idle  <= 1'b0;
        m_t     <= 0;
        m_slot  <= int'(req_slot);
        m_lat   <= lat_of(first_hit(req_slot));
        m_reads <= reads_of(first_hit(req_slot));
        m_col   <= (first_hit(req_slot) >= 0);
      end
    end else if ((m_t >= m_lat - 1) && res_ready) begin
      m_idle <= 1'b1;
      m_chk  <= (m_chk == 16'hFFFF) ? m_chk : m_chk + 16'd1;
      if (m_col && (m_hit != 16'hFFFF)) m_hit <= m_hit + 16'd1;
    end else begin
      m_t <= m_t + 1;
    end
  end

  // Hand-computed expectations for the current directed check.
  int          lit_lat   = 0;
  int          lit_reads = 0;
  bit          lit_col   = 1'b0;
  logic [15:0] lit_chk   = '0;
  logic [15:0] lit_hit   = '0;
  int          tmo       = 0;

  int n_chk = 0;
  int n_err = 0;
  int tmo_seen = 0;
  int bsy_n = 0;
  int rd_n  = 0;
  bit rv_prev = 1'b0;
  bit exp_rv, exp_rd;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tmo != tmo_seen) begin
      chk("wait_timeout", tmo, tmo_seen);
      tmo_seen = tmo;
    end
    if (rst) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_obs_rd_en", obs_rd_en, 0);
      chk("rst_agt_rd_en", agt_rd_en, 0);
      chk("rst_obs_addr", obs_addr, 0);
      chk("rst_agt_addr", agt_addr, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_collide", res_collide, 0);
      chk("rst_res_slot", res_slot, 0);
      chk("rst_chk_cnt", chk_cnt, 0);
      chk("rst_hit_cnt", hit_cnt, 0);
      bsy_n   = 0;
      rd_n    = 0;
      rv_prev = 1'b0;
    end else begin
      exp_rv = !m_idle && (m_t >= m_lat - 1);
      exp_rd = !m_idle && (m_t < m_reads);
      chk("req_ready", req_ready, m_idle);
      chk("busy", busy, !m_idle);
      chk("res_valid", res_valid, exp_rv);
      chk("obs_rd_en", obs_rd_en, exp_rd);
      chk("agt_rd_en", agt_rd_en, exp_rd);
      if (exp_rd) begin
        chk("obs_addr", obs_addr, m_t);
        chk("agt_addr", agt_addr, m_slot * WORD_NUM + m_t);
      end
      if (exp_rv) begin
        chk("res_collide", res_collide, m_col);
        chk("res_slot", res_slot, m_slot);
      end
      chk("chk_cnt", chk_cnt, m_chk);
      chk("hit_cnt", hit_cnt, m_hit);

      if (busy && !res_valid) bsy_n++;
      if (busy && obs_rd_en) rd_n++;
      if (res_valid && !rv_prev) begin
        chk("latency_lit", bsy_n + 1, lit_lat);
        chk("latency_model", bsy_n + 1, m_lat);
        chk("reads_lit", rd_n, lit_reads);
        chk("collide_lit", res_collide, lit_col);
      end
      if (!busy && rv_prev) begin
        chk("chk_cnt_lit", chk_cnt, lit_chk);
        chk("hit_cnt_lit", hit_cnt, lit_hit);
      end
      if (!busy) begin
        bsy_n = 0;
        rd_n  = 0;
      end
      rv_prev = res_valid;
    end
  end

  task automatic run_check(input logic [SLOT_W-1:0] slot, input int hold,
                           input int e_lat, input int e_reads, input bit e_col,
                           input logic [15:0] e_chk, input logic [15:0] e_hit);
    int n;
    lit_lat   = e_lat;
    lit_reads = e_reads;
    lit_col   = e_col;
    lit_chk   = e_chk;
    lit_hit   = e_hit;
    @(negedge clk); #1;
    req_valid = 1'b1;
    req_slot  = slot;
    res_ready = (hold == 0);
    @(negedge clk); #1;
    // Under backpressure keep a competing request (other slot) asserted.
    req_valid = (hold > 0);
    if (hold > 0) req_slot = ~slot;
    n = 0;
    while (!res_valid && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (!res_valid) tmo++;
    repeat (hold) begin
      @(negedge clk); #1;
    end
    res_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_slot  = '0;
    res_ready = 1'b0;
    for (int k = 0; k < WORD_NUM; k++) begin
      obs_mem[k] = '0;
      for (int s = 0; s < 16; s++) agt_mem[s][k] = '0;
    end
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Empty maps: full scan, no collision.
    run_check(4'd3, 0, 6, 4, 1'b0, 16'd1, 16'd0);

    // Overlap at bit 0 of word 0: early exit after two reads.
    obs_mem[0]    = 16'h0001;
    agt_mem[5][0] = 16'h0001;
    run_check(4'd5, 0, 3, 2, 1'b1, 16'd2, 16'd1);

    // Overlap at the top bit of the last word: found in the drain cycle.
    obs_mem[3]    = 16'h8000;
    agt_mem[2][3] = 16'h8000;
    run_check(4'd2, 0, 6, 4, 1'b1, 16'd3, 16'd2);

    // Same check held in DONE for five cycles with a competing request.
    run_check(4'd2, 5, 6, 4, 1'b1, 16'd4, 16'd3);

    // Interleaved but disjoint bits: no collision.
    obs_mem[1]    = 16'h00F0;
    agt_mem[1][0] = 16'hFFFE;
    agt_mem[1][1] = 16'h0F0F;
    run_check(4'd1, 0, 6, 4, 1'b0, 16'd5, 16'd3);

    // Overlap in word 2: detected while the last read is being issued.
    obs_mem[2]    = 16'h0100;
    agt_mem[6][2] = 16'h0300;
    run_check(4'd6, 0, 5, 4, 1'b1, 16'd6, 16'd4);

    // Reset pulse inside the second READ cycle, between clock edges.
    @(negedge clk); #1;
    req_valid = 1'b1;
    req_slot  = 4'd3;
    @(negedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    run_check(4'd5, 0, 3, 2, 1'b1, 16'd1, 16'd1);

    // Counters preloaded one below saturation.
    @(negedge clk); #2;
    force dut.chk_cnt_q = 16'hFFFE;
    force dut.hit_cnt_q = 16'hFFFE;
    preload = 1'b1;
    @(posedge clk);
    @(negedge clk); #2;
    release dut.chk_cnt_q;
    release dut.hit_cnt_q;
    preload = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_check(4'd5, 0, 3, 2, 1'b1, 16'hFFFF, 16'hFFFF);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
